// File: rtl/mac_sequencer_pkg.sv
// Shared accelerator definitions: default widths and the sequencer state encoding.
package mac_sequencer_pkg;

  localparam int unsigned DATA_WIDTH_DEF   = 8;
  localparam int unsigned OUTPUT_WIDTH_DEF = 16;
  localparam int unsigned LEN_WIDTH_DEF    = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_HOLD  = 2'd3
  } seq_state_e;

endpackage

// File: rtl/mac_sequencer_if.sv
// Job control, operand stream, MAC side-band and result stream of the sequencer.
interface mac_sequencer_if
  import mac_sequencer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = DATA_WIDTH_DEF,
  parameter int unsigned OUTPUT_WIDTH = OUTPUT_WIDTH_DEF,
  parameter int unsigned LEN_WIDTH    = LEN_WIDTH_DEF
);

  logic                    start;
  logic [LEN_WIDTH-1:0]    vec_len;
  logic                    busy;

  logic                    in_valid;
  logic                    in_ready;
  logic [DATA_WIDTH-1:0]   in_data;
  logic [DATA_WIDTH-1:0]   in_weight;

  logic                    mac_enable;
  logic                    mac_clear;
  logic [DATA_WIDTH-1:0]   mac_data;
  logic [DATA_WIDTH-1:0]   mac_weight;
  logic [OUTPUT_WIDTH-1:0] mac_out;
  logic [OUTPUT_WIDTH-1:0] mac_act;
  logic                    mac_ovf;

  logic                    res_valid;
  logic                    res_ready;
  logic [OUTPUT_WIDTH-1:0] res_data;
  logic [OUTPUT_WIDTH-1:0] res_act;
  logic                    res_ovf;

  // Sequencer view
  modport master (
    input  start, vec_len, in_valid, in_data, in_weight,
           mac_out, mac_act, mac_ovf, res_ready,
    output busy, in_ready, mac_enable, mac_clear, mac_data, mac_weight,
           res_valid, res_data, res_act, res_ovf
  );

  // Environment view (job source, operand source, MAC, result sink)
  modport slave (
    output start, vec_len, in_valid, in_data, in_weight,
           mac_out, mac_act, mac_ovf, res_ready,
    input  busy, in_ready, mac_enable, mac_clear, mac_data, mac_weight,
           res_valid, res_data, res_act, res_ovf
  );

endinterface

// File: rtl/mac_result_reg.sv
// Result register stage: captures the MAC outputs once per job and holds them.
module mac_result_reg
  import mac_sequencer_pkg::*;
#(
  parameter int unsigned OUTPUT_WIDTH = OUTPUT_WIDTH_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    capture,
  input  logic [OUTPUT_WIDTH-1:0] mac_out,
  input  logic [OUTPUT_WIDTH-1:0] mac_act,
  input  logic                    mac_ovf,
  output logic [OUTPUT_WIDTH-1:0] res_data,
  output logic [OUTPUT_WIDTH-1:0] res_act,
  output logic                    res_ovf
);

  logic [OUTPUT_WIDTH-1:0] data_q, data_d;
  logic [OUTPUT_WIDTH-1:0] act_q, act_d;
  logic                    ovf_q, ovf_d;

  // Load on capture, otherwise hold
  always_comb begin
    data_d = data_q;
    act_d  = act_q;
    ovf_d  = ovf_q;
    if (capture) begin
      data_d = mac_out;
      act_d  = mac_act;
      ovf_d  = mac_ovf;
    end
  end

  // Result flops with synchronous clear
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      act_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      data_q <= data_d;
      act_q  <= act_d;
      ovf_q  <= ovf_d;
    end
  end

  // Outputs read as zero for as long as reset is held, not just after the edge
  assign res_data = rst ? '0 : data_q;
  assign res_act  = rst ? '0 : act_q;
  assign res_ovf  = ovf_q & ~rst;

endmodule

// File: rtl/mac_sequencer.sv
// Dot-product sequencer: feeds one vector of operand beats to an external MAC
// and presents the accumulated result on a valid/ready result stream.
module mac_sequencer
  import mac_sequencer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = DATA_WIDTH_DEF,
  parameter int unsigned OUTPUT_WIDTH = OUTPUT_WIDTH_DEF,
  parameter int unsigned LEN_WIDTH    = LEN_WIDTH_DEF
) (
  input logic            clk,
  input logic            rst,
  mac_sequencer_if.master bus
);

  seq_state_e           state_q, state_d;
  logic [LEN_WIDTH-1:0] cnt_q, cnt_d;
  logic [LEN_WIDTH-1:0] len_q, len_d;

  logic in_ready_c;
  logic mac_enable_c;
  logic mac_clear_c;
  logic capture_c;
  logic res_valid_c;
  logic last_beat_c;

  assign last_beat_c = (cnt_q == LEN_WIDTH'(len_q - LEN_WIDTH'(1)));

  // Next-state, counter and per-state control decode
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    len_d        = len_q;
    in_ready_c   = 1'b0;
    mac_enable_c = 1'b0;
    mac_clear_c  = 1'b0;
    capture_c    = 1'b0;
    res_valid_c  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          if (bus.vec_len != '0) begin
            len_d   = LEN_WIDTH'(bus.vec_len);
            cnt_d   = '0;
            state_d = ST_RUN;
          end else begin
            // Empty vector: zero the accumulator so the captured result is 0
            mac_clear_c = 1'b1;
            state_d     = ST_DRAIN;
          end
        end
      end
      ST_RUN: begin
        in_ready_c = 1'b1;
        if (bus.in_valid) begin
          mac_enable_c = 1'b1;
          mac_clear_c  = (cnt_q == '0);
          cnt_d        = LEN_WIDTH'(cnt_q + LEN_WIDTH'(1));
          if (last_beat_c) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        capture_c = 1'b1;
        state_d   = ST_HOLD;
      end
      ST_HOLD: begin
        res_valid_c = 1'b1;
        if (bus.res_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, beat counter and latched length
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
    end
  end

  // Control outputs are forced low while reset is held
  assign bus.in_ready   = in_ready_c & ~rst;
  assign bus.mac_enable = mac_enable_c & ~rst;
  assign bus.mac_clear  = mac_clear_c & ~rst;
  assign bus.res_valid  = res_valid_c & ~rst;
  assign bus.busy       = (state_q != ST_IDLE) & ~rst;
  assign bus.mac_data   = DATA_WIDTH'(bus.in_data);
  assign bus.mac_weight = DATA_WIDTH'(bus.in_weight);

  mac_result_reg #(
    .OUTPUT_WIDTH (OUTPUT_WIDTH)
  ) u_result_reg (
    .clk      (clk),
    .rst      (rst),
    .capture  (capture_c & ~rst),
    .mac_out  (OUTPUT_WIDTH'(bus.mac_out)),
    .mac_act  (OUTPUT_WIDTH'(bus.mac_act)),
    .mac_ovf  (bus.mac_ovf),
    .res_data (bus.res_data),
    .res_act  (bus.res_act),
    .res_ovf  (bus.res_ovf)
  );

endmodule

// File: tb/tb_mac_sequencer.sv
// Bench for mac_sequencer with a behavioural MAC (sticky overflow, ReLU activation).
module tb_mac_sequencer;

  logic clk;
  logic rst;
  logic rst_n;

  int tests_run;
  int tests_failed;

  mac_sequencer_if #(.DATA_WIDTH(8), .OUTPUT_WIDTH(16), .LEN_WIDTH(8)) bus ();

  mac_sequencer #(
    .DATA_WIDTH   (8),
    .OUTPUT_WIDTH (16),
    .LEN_WIDTH    (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural MAC beside the sequencer, reset by the inverted rst
  assign rst_n = ~rst;
  logic [15:0] acc_q;
  logic        ovf_q;
  logic [15:0] prod;
  logic [16:0] sum;
  assign prod = 16'(bus.mac_data) * 16'(bus.mac_weight);
  assign sum  = 17'(acc_q) + 17'(prod);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      ovf_q <= 1'b0;
    end else if (bus.mac_clear) begin
      acc_q <= bus.mac_enable ? prod : 16'd0;
      ovf_q <= 1'b0;
    end else if (bus.mac_enable) begin
      acc_q <= sum[15:0];
      ovf_q <= ovf_q | sum[16];
    end
  end
  assign bus.mac_out = acc_q;
  assign bus.mac_act = acc_q[15] ? 16'd0 : acc_q;
  assign bus.mac_ovf = ovf_q;

  typedef struct packed {
    logic [7:0]       len;
    logic [3:0][7:0]  d;
    logic [3:0][7:0]  w;
    logic [15:0]      exp_d;
    logic [15:0]      exp_a;
    logic             exp_o;
  } vec_t;

  vec_t tbl [7];

  function automatic vec_t mk(input logic [7:0] len,
                              input logic [7:0] d0, w0, d1, w1, d2, w2, d3, w3,
                              input logic [15:0] ed, ea, input logic eo);
    vec_t v;
    v.len = len;
    v.d[0] = d0; v.w[0] = w0;
    v.d[1] = d1; v.w[1] = w1;
    v.d[2] = d2; v.w[2] = w2;
    v.d[3] = d3; v.w[3] = w3;
    v.exp_d = ed;
    v.exp_a = ea;
    v.exp_o = eo;
    return v;
  endfunction

  task automatic chk1(input string name, input logic act, input logic exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue start from IDLE; leaves the DUT one edge later
  task automatic start_job(input logic [7:0] len, input string tag);
    bus.start   = 1'b1;
    bus.vec_len = len;
    #1;
    chk1({tag, "_idle_busy"}, bus.busy, 1'b0);
    if (len == 8'd0) begin
      chk1({tag, "_len0_clear"}, bus.mac_clear, 1'b1);
      chk1({tag, "_len0_enable"}, bus.mac_enable, 1'b0);
    end
    step();
    bus.start = 1'b0;
  endtask

  // Present one beat in RUN; it must be accepted in this cycle
  task automatic do_beat(input logic [7:0] d, input logic [7:0] w,
                         input logic first, input string tag);
    bus.in_valid  = 1'b1;
    bus.in_data   = d;
    bus.in_weight = w;
    #1;
    chk1({tag, "_in_ready"}, bus.in_ready, 1'b1);
    chk1({tag, "_mac_enable"}, bus.mac_enable, 1'b1);
    chk1({tag, "_mac_clear"}, bus.mac_clear, first);
    step();
    bus.in_valid = 1'b0;
  endtask

  // DRAIN cycle, then HOLD with the result, then accept it
  task automatic finish_job(input logic [15:0] ed, input logic [15:0] ea,
                            input logic eo, input string tag);
    #1;
    chk1({tag, "_drain_valid"}, bus.res_valid, 1'b0);
    chk1({tag, "_drain_busy"}, bus.busy, 1'b1);
    chk1({tag, "_drain_ready"}, bus.in_ready, 1'b0);
    step();
    chk1({tag, "_hold_valid"}, bus.res_valid, 1'b1);
    chk1({tag, "_hold_ready"}, bus.in_ready, 1'b0);
    chk16({tag, "_res_data"}, bus.res_data, ed);
    chk16({tag, "_res_act"}, bus.res_act, ea);
    chk1({tag, "_res_ovf"}, bus.res_ovf, eo);
    bus.res_ready = 1'b1;
    step();
    bus.res_ready = 1'b0;
    chk1({tag, "_back_idle"}, bus.busy, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.vec_len   = '0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_weight = '0;
    bus.res_ready = 1'b0;

    tbl[0] = mk(8'd3, 8'd2, 8'd3, 8'd4, 8'd5, 8'd1, 8'd1, 8'd0, 8'd0, 16'd27, 16'd27, 1'b0);
    tbl[1] = mk(8'd1, 8'd1, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 16'd1, 16'd1, 1'b0);
    tbl[2] = mk(8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 16'd0, 16'd0, 1'b0);
    tbl[3] = mk(8'd2, 8'd200, 8'd200, 8'd100, 8'd100, 8'd0, 8'd0, 8'd0, 8'd0, 16'd50000, 16'd0, 1'b0);
    tbl[4] = mk(8'd2, 8'd255, 8'd255, 8'd100, 8'd10, 8'd0, 8'd0, 8'd0, 8'd0, 16'd489, 16'd489, 1'b1);
    tbl[5] = mk(8'd1, 8'd3, 8'd4, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 16'd12, 16'd12, 1'b0);
    tbl[6] = mk(8'd4, 8'd10, 8'd10, 8'd10, 8'd10, 8'd10, 8'd10, 8'd10, 8'd10, 16'd400, 16'd400, 1'b0);

    // Reset state, during and after reset
    step();
    step();
    chk1("rst_busy", bus.busy, 1'b0);
    chk1("rst_in_ready", bus.in_ready, 1'b0);
    chk1("rst_mac_enable", bus.mac_enable, 1'b0);
    chk1("rst_mac_clear", bus.mac_clear, 1'b0);
    chk1("rst_res_valid", bus.res_valid, 1'b0);
    chk1("rst_res_ovf", bus.res_ovf, 1'b0);
    chk16("rst_res_data", bus.res_data, 16'd0);
    chk16("rst_res_act", bus.res_act, 16'd0);
    rst = 1'b0;
    step();
    chk1("post_rst_busy", bus.busy, 1'b0);
    chk1("post_rst_res_valid", bus.res_valid, 1'b0);
    chk16("post_rst_res_data", bus.res_data, 16'd0);

    // Table jobs with back-to-back beats
    for (int i = 0; i < 7; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      start_job(tbl[i].len, tag);
      for (int b = 0; b < int'(tbl[i].len); b++) begin
        do_beat(tbl[i].d[b], tbl[i].w[b], logic'(b == 0), tag);
      end
      finish_job(tbl[i].exp_d, tbl[i].exp_a, tbl[i].exp_o, tag);
    end

    // Gapped input, held result, start ignored in HOLD
    start_job(8'd2, "gap");
    for (int b = 0; b < 2; b++) begin
      for (int g = 0; g < 5; g++) begin
        #1;
        chk1("gap_stall_ready", bus.in_ready, 1'b1);
        chk1("gap_stall_enable", bus.mac_enable, 1'b0);
        step();
      end
      if (b == 0) do_beat(8'd7, 8'd8, 1'b1, "gap");
      else        do_beat(8'd9, 8'd10, 1'b0, "gap");
    end
    step();
    for (int h = 0; h < 4; h++) begin
      if (h == 1) begin
        bus.start   = 1'b1;
        bus.vec_len = 8'd5;
      end else begin
        bus.start = 1'b0;
      end
      #1;
      chk1("gap_hold_valid", bus.res_valid, 1'b1);
      chk16("gap_hold_data", bus.res_data, 16'd146);
      chk1("gap_hold_ovf", bus.res_ovf, 1'b0);
      step();
    end
    bus.res_ready = 1'b1;
    step();
    bus.res_ready = 1'b0;
    chk1("gap_exit_idle", bus.busy, 1'b0);
    // Start in the very next cycle after the HOLD exit
    start_job(8'd1, "restart");
    do_beat(8'd5, 8'd5, 1'b1, "restart");
    finish_job(16'd25, 16'd25, 1'b0, "restart");

    // Reset mid-RUN after 2 of 4 beats
    start_job(8'd4, "rstrun");
    do_beat(8'd6, 8'd6, 1'b1, "rstrun");
    do_beat(8'd6, 8'd6, 1'b0, "rstrun");
    rst           = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'd6;
    bus.in_weight = 8'd6;
    #1;
    chk1("rstrun_in_ready", bus.in_ready, 1'b0);
    chk1("rstrun_enable", bus.mac_enable, 1'b0);
    chk1("rstrun_busy", bus.busy, 1'b0);
    step();
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    chk1("rstrun_idle", bus.busy, 1'b0);
    chk1("rstrun_no_result", bus.res_valid, 1'b0);
    chk16("rstrun_res_data", bus.res_data, 16'd0);
    step();
    chk1("rstrun_still_idle", bus.busy, 1'b0);
    start_job(8'd1, "after_rst");
    do_beat(8'd3, 8'd3, 1'b1, "after_rst");
    finish_job(16'd9, 16'd9, 1'b0, "after_rst");

    // Maximum length runs all 255 beats with no counter wrap
    start_job(8'd255, "full");
    for (int b = 0; b < 255; b++) begin
      do_beat(8'd1, 8'd1, logic'(b == 0), "full");
    end
    finish_job(16'd255, 16'd255, 1'b0, "full");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/mac_sequencer.md
MAC_SEQUENCER -- requirements
Module: mac_sequencer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, operand width passed to the MAC.
REQ-002 SHALL have parameter OUTPUT_WIDTH, default 16, MAC result width.
REQ-003 SHALL have parameter LEN_WIDTH, default 8, vector-length field width.
REQ-004 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port start  input  1  begin one dot product, sampled only in IDLE.
REQ-007 SHALL have port vec_len  input  LEN_WIDTH  beat count, latched when start is accepted.
REQ-008 SHALL have ports in_valid (input, 1), in_ready (output, 1), in_data (input, DATA_WIDTH), in_weight (input, DATA_WIDTH): operand stream.
REQ-009 SHALL have ports mac_enable (output, 1), mac_clear (output, 1), mac_data (output, DATA_WIDTH), mac_weight (output, DATA_WIDTH): MAC control and operands.
REQ-010 SHALL have ports mac_out (input, OUTPUT_WIDTH), mac_act (input, OUTPUT_WIDTH), mac_ovf (input, 1): MAC results.
REQ-011 SHALL have ports res_valid (output, 1), res_ready (input, 1), res_data (output, OUTPUT_WIDTH), res_act (output, OUTPUT_WIDTH), res_ovf (output, 1): result stream.
REQ-012 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-013 SHALL implement four states: IDLE, RUN, DRAIN, HOLD.
REQ-014 IDLE: start=1 with vec_len>0 SHALL latch vec_len, zero the beat counter and go to RUN.
REQ-015 IDLE: start=1 with vec_len=0 SHALL assert mac_clear=1 with mac_enable=0 for one cycle and go to DRAIN (result 0).
REQ-016 in_ready SHALL be 1 exactly in RUN; a beat is accepted when in_valid & in_ready.
REQ-017 mac_enable SHALL equal the accept condition; mac_data and mac_weight SHALL be combinational copies of in_data and in_weight.
REQ-018 mac_clear SHALL be 1 on the accepted beat with counter=0, so the first product replaces the prior sum and clears overflow; it SHALL be 0 otherwise (except REQ-015).
REQ-019 The counter SHALL increment per accepted beat; the beat where counter=len-1 SHALL move RUN->DRAIN.
REQ-020 in_valid=0 in RUN SHALL stall: no enable and no counter change, for an unbounded time.
REQ-021 DRAIN SHALL last one cycle: capture mac_out, mac_act and mac_ovf into the result registers, then go to HOLD.
REQ-022 HOLD: res_valid=1 with outputs stable; res_ready=1 SHALL return to IDLE on that edge.
REQ-023 start outside IDLE SHALL be ignored; start in the cycle after a HOLD->IDLE exit SHALL be accepted.
REQ-024 Latency: the result is valid 2 cycles after the last accepted beat's edge (DRAIN, then HOLD).
REQ-025 vec_len=2^LEN_WIDTH-1 SHALL run the full count without counter wrap.

Reset
REQ-026 rst=1 SHALL force IDLE, counter 0 and latched length 0 on the next edge, from any state including mid-RUN.
REQ-027 While rst=1 and after it: in_ready, mac_enable, mac_clear, res_valid, busy, res_ovf = 0; res_data = res_act = 0.
REQ-028 On reset mid-vector, no partial result SHALL be presented; the next job's mac_clear discards the stale sum.

Structure
REQ-029 The state encoding SHALL be a typedef in the shared accelerator package, alongside the default widths.
REQ-030 The block SHALL contain no MAC; mac_unit SHALL be instantiated beside it at the top level, with rst inverted to drive rst_n.
REQ-031 The output register stage SHALL be the one natural sub-module, named mac_result_reg.

Verification
REQ-032 Test: vec_len=3, beats (2,3),(4,5),(1,1) back-to-back -> res_data=27, res_ovf=0, and res_valid rises 2 cycles after the 3rd beat.
REQ-033 Test: vec_len=0 -> res_valid with res_data=0, res_ovf=0; no in_ready pulse.
REQ-034 Test: vec_len=2, in_valid gaps of 5 cycles, res_ready held low 4 cycles -> res_data=sum; outputs stable during HOLD; start during HOLD ignored.
REQ-035 Test: rst asserted mid-RUN after 2 of 4 beats -> IDLE next edge; new job vec_len=1 (3,3) -> res_data=9.
REQ-036 Test: two consecutive jobs, second vec_len=1 (1,1) -> res_data=1, proving mac_clear on the first beat.
REQ-037 Test: products summing past 2^OUTPUT_WIDTH -> res_data=truncated low bits, res_ovf as the MAC reports.
